receiver: RTL and testbench

- Serial frame receiver; the mirror stage of the transmitter.
- Consumes the remote transmitter's serial line (its o_tx) and recovers bytes using i_clk oversampling.
- Checks frame structure and checksum, then writes payload bytes into the io_module-side RX buffer.
- Reports commit/discard, frame count and status so io_module can raise o_rx_int and feed the local lock indication back to the transmitter.

---
 rtl/receiver_pkg.sv | 28 ++
 rtl/rx_byte_deserializer.sv | 103 ++++++++++
 rtl/receiver.sv | 192 +++++++++++++++++++
 tb/tb_receiver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// Shared definitions for the serial frame link: sync byte, status bit positions
// and FSM state encodings used by the transmitter, receiver and io_module.
package receiver_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int ST_LOCKED   = 0;
  localparam int ST_FRAMING  = 1;
  localparam int ST_CSUM     = 2;
  localparam int ST_TIMEOUT  = 3;
  localparam int ST_OVERFLOW = 4;
  localparam int ST_LENGTH   = 5;

  typedef enum logic [1:0] {
    FR_HUNT,
    FR_LEN,
    FR_PAYLOAD,
    FR_CSUM
  } frame_state_t;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_t;

endpackage

// File: rtl/rx_byte_deserializer.sv
// Oversampling UART-style byte deserializer: synchronizes the line, finds start
// bits, samples mid-bit and flags framing errors and idle bit periods.
module rx_byte_deserializer
  import receiver_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err,
  output logic       idle_tick
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  logic rx_meta, rx_sync, rx_prev;

  bit_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;

  // Synchronizer flops reset to the idle-high line level to avoid a fake start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= BIT_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CW'(1);
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    byte_valid   = 1'b0;
    framing_err  = 1'b0;
    idle_tick    = 1'b0;
    case (state_reg)
      BIT_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_next = BIT_START;
          cnt_next   = '0;
        end else if (cnt_reg == FULL_LAST) begin
          idle_tick = 1'b1;
          cnt_next  = '0;
        end
      end
      BIT_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_sync ? BIT_IDLE : BIT_DATA;
        end
      end
      BIT_DATA: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_sync, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = BIT_STOP;
        end
      end
      BIT_STOP: begin
        // Leave straight to IDLE so a start bit right after the stop is caught.
        if (cnt_reg == FULL_LAST) begin
          cnt_next    = '0;
          state_next  = BIT_IDLE;
          byte_valid  = rx_sync;
          framing_err = !rx_sync;
        end
      end
      default: state_next = BIT_IDLE;
    endcase
  end

  assign byte_data = shift_reg;

endmodule

// File: rtl/receiver.sv
// Frame receiver: hunts for the sync byte, checks length and checksum, streams
// payload to the RX buffer and reports commit/discard, frame count and status.
module receiver
  import receiver_pkg::*;
#(
  parameter int OVERSAMPLE   = 8,
  parameter int LOCK_COUNT   = 2,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_pop_frame,
  input  logic       i_clear_status,
  output logic [7:0] o_data,
  output logic       o_data_we,
  output logic       o_commit,
  output logic       o_discard,
  output logic [7:0] o_frames_count,
  output logic [7:0] o_status,
  output logic       o_locked
);

  localparam int GW = $clog2(TIMEOUT_BITS + 1);
  localparam int RW = $clog2(LOCK_COUNT + 1);

  logic [7:0] byte_data;
  logic       byte_valid, framing_err, idle_tick;

  rx_byte_deserializer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_deser (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .rx         (i_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .framing_err(framing_err),
    .idle_tick  (idle_tick)
  );

  frame_state_t   frame_state_reg, frame_state_next;
  logic [7:0]     remain_reg, remain_next;
  logic [7:0]     csum_reg, csum_next;
  logic           wrote_reg, wrote_next;
  logic [GW-1:0]  gap_reg, gap_next;
  logic [RW-1:0]  run_reg, run_next;
  logic [7:0]     count_reg, count_next;
  logic [5:1]     sticky_reg, sticky_next;
  logic [7:0]     data_reg, data_next;
  logic           data_we_reg, data_we_next;
  logic           commit_reg, commit_next;
  logic           discard_reg, discard_next;
  logic           locked_reg, locked_next;

  logic       abort, timeout, pop_ok;
  logic [5:1] err_set;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_state_reg <= FR_HUNT;
      remain_reg      <= '0;
      csum_reg        <= '0;
      wrote_reg       <= 1'b0;
      gap_reg         <= '0;
      run_reg         <= '0;
      count_reg       <= '0;
      sticky_reg      <= '0;
      data_reg        <= '0;
      data_we_reg     <= 1'b0;
      commit_reg      <= 1'b0;
      discard_reg     <= 1'b0;
      locked_reg      <= 1'b0;
    end else begin
      frame_state_reg <= frame_state_next;
      remain_reg      <= remain_next;
      csum_reg        <= csum_next;
      wrote_reg       <= wrote_next;
      gap_reg         <= gap_next;
      run_reg         <= run_next;
      count_reg       <= count_next;
      sticky_reg      <= sticky_next;
      data_reg        <= data_next;
      data_we_reg     <= data_we_next;
      commit_reg      <= commit_next;
      discard_reg     <= discard_next;
      locked_reg      <= locked_next;
    end
  end

  always_comb begin
    frame_state_next = frame_state_reg;
    remain_next      = remain_reg;
    csum_next        = csum_reg;
    wrote_next       = wrote_reg;
    gap_next         = gap_reg;
    run_next         = run_reg;
    data_next        = data_reg;
    data_we_next     = 1'b0;
    commit_next      = 1'b0;
    discard_next     = 1'b0;
    abort            = 1'b0;
    err_set          = '0;

    // Gap only measures silence inside a frame; any received byte restarts it.
    timeout = (frame_state_reg != FR_HUNT) && idle_tick &&
              (gap_reg == GW'(TIMEOUT_BITS - 1));
    if (frame_state_reg == FR_HUNT || byte_valid || framing_err) gap_next = '0;
    else if (idle_tick) gap_next = gap_reg + GW'(1);

    case (frame_state_reg)
      FR_HUNT: begin
        wrote_next = 1'b0;
        if (byte_valid && byte_data == SYNC_BYTE) frame_state_next = FR_LEN;
        if (framing_err) err_set[ST_FRAMING] = 1'b1;
      end
      FR_LEN: begin
        if (byte_valid) begin
          if (byte_data == 8'd0) begin
            err_set[ST_LENGTH] = 1'b1;
            frame_state_next   = FR_HUNT;
          end else begin
            remain_next      = byte_data;
            csum_next        = byte_data;
            frame_state_next = FR_PAYLOAD;
          end
        end
      end
      FR_PAYLOAD: begin
        if (byte_valid) begin
          data_next    = byte_data;
          data_we_next = 1'b1;
          wrote_next   = 1'b1;
          csum_next    = csum_reg + byte_data;
          remain_next  = remain_reg - 8'd1;
          if (remain_reg == 8'd1) frame_state_next = FR_CSUM;
        end
      end
      FR_CSUM: begin
        if (byte_valid) begin
          frame_state_next = FR_HUNT;
          if (byte_data != csum_reg) begin
            err_set[ST_CSUM] = 1'b1;
            abort            = 1'b1;
          end else if (count_reg == 8'hFF) begin
            // No room to count another frame: drop it like a bad one.
            err_set[ST_OVERFLOW] = 1'b1;
            discard_next         = wrote_reg;
          end else begin
            commit_next = 1'b1;
            if (run_reg != RW'(LOCK_COUNT)) run_next = run_reg + RW'(1);
          end
        end
      end
      default: frame_state_next = FR_HUNT;
    endcase

    if (frame_state_reg != FR_HUNT && framing_err) begin
      err_set[ST_FRAMING] = 1'b1;
      abort               = 1'b1;
    end
    if (timeout) begin
      err_set[ST_TIMEOUT] = 1'b1;
      abort               = 1'b1;
    end
    if (abort) begin
      discard_next     = wrote_reg;
      frame_state_next = FR_HUNT;
    end

    if (err_set[ST_FRAMING] || err_set[ST_CSUM] || err_set[ST_TIMEOUT] || err_set[ST_LENGTH])
      run_next = '0;
    locked_next = (run_next >= RW'(LOCK_COUNT));

    sticky_next = (i_clear_status ? 5'd0 : sticky_reg) | err_set;

    // The count follows the visible commit pulse so a pop in that cycle cancels it.
    pop_ok = i_pop_frame && (count_reg != 8'd0);
    count_next = count_reg;
    if (commit_reg && !pop_ok && count_reg != 8'hFF) count_next = count_reg + 8'd1;
    else if (!commit_reg && pop_ok) count_next = count_reg - 8'd1;
  end

  assign o_data         = data_reg;
  assign o_data_we      = data_we_reg;
  assign o_commit       = commit_reg;
  assign o_discard      = discard_reg;
  assign o_frames_count = count_reg;
  assign o_locked       = locked_reg;
  assign o_status       = {2'b00, sticky_reg, locked_reg};

endmodule

// File: tb/tb_receiver.sv
// Randomized self-checking bench for receiver: drives serial frames and
// compares against a frame-level model of count, status and written bytes.
module tb_receiver;

  localparam int OS   = 4;
  localparam int LOCK = 2;
  localparam int TMO  = 32;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n, rx, pop, clr;
  logic [7:0] o_data, o_frames_count, o_status;
  logic       o_data_we, o_commit, o_discard, o_locked;

  always #5 clk = ~clk;

  receiver #(
    .OVERSAMPLE  (OS),
    .LOCK_COUNT  (LOCK),
    .TIMEOUT_BITS(TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx          (rx),
    .i_pop_frame   (pop),
    .i_clear_status(clr),
    .o_data        (o_data),
    .o_data_we     (o_data_we),
    .o_commit      (o_commit),
    .o_discard     (o_discard),
    .o_frames_count(o_frames_count),
    .o_status      (o_status),
    .o_locked      (o_locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference model
  int         exp_count = 0;
  int         exp_run = 0;
  logic [5:1] exp_sticky = '0;

  function automatic logic [7:0] exp_status();
    return {2'b00, exp_sticky, (exp_run >= LOCK)};
  endfunction

  // Output monitor
  byte_q_t got_q;
  int      n_commit = 0;
  int      n_discard = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_data_we) got_q.push_back(o_data);
      if (o_commit) n_commit++;
      if (o_discard) n_discard++;
      if (o_data_we || o_commit || o_discard)
        check("strobe_excl", 32'(o_data_we) + 32'(o_commit) + 32'(o_discard), 1);
    end
  end

  task automatic clear_mon();
    got_q.delete();
    n_commit  = 0;
    n_discard = 0;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * OS) @(negedge clk);
  endtask

  task automatic pulse_pop();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (exp_count > 0) exp_count--;
  endtask

  function automatic byte_q_t rand_payload(input int len);
    byte_q_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic wait_commit_pop();
    bit seen = 0;
    for (int k = 0; k < 16 * OS && !seen; k++) begin
      @(negedge clk);
      if (o_commit) begin
        seen = 1;
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
      end
    end
    check("pop_commit_seen", 32'(seen), 1);
  endtask

  task automatic check_outcome(input string name, input byte_q_t exp_w, input int exp_c, input int exp_d);
    check({name, "_nwrites"}, got_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      check({name, "_data"}, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_w[i]});
    check({name, "_commit"}, n_commit, exp_c);
    check({name, "_discard"}, n_discard, exp_d);
    check({name, "_count"}, o_frames_count, exp_count);
    check({name, "_status"}, o_status, exp_status());
    check({name, "_locked"}, o_locked, exp_run >= LOCK);
  endtask

  // fe_pos: stream index whose stop bit is 0 (-1 none); glitch_after: stream index
  // after which a short low pulse is inserted (-1 none).
  task automatic run_frame(input byte_q_t pl, input int cs_delta, input int fe_pos,
                           input int glitch_after, input bit pop_on_commit, input string name);
    byte_q_t    stream, exp_w;
    logic [7:0] cs;
    int         exp_c = 0, exp_d = 0, nw;
    cs = 8'(pl.size());
    foreach (pl[i]) cs = cs + pl[i];
    cs = cs + 8'(cs_delta);
    stream.push_back(8'hA5);
    stream.push_back(8'(pl.size()));
    foreach (pl[i]) stream.push_back(pl[i]);
    stream.push_back(cs);

    if (fe_pos >= 0) begin
      nw = fe_pos - 2;
      if (nw < 0) nw = 0;
      if (nw > pl.size()) nw = pl.size();
      for (int i = 0; i < nw; i++) exp_w.push_back(pl[i]);
      exp_d = (nw > 0);
      exp_sticky[1] = 1'b1;
      exp_run = 0;
    end else if (pl.size() == 0) begin
      exp_sticky[5] = 1'b1;
      exp_run = 0;
    end else if (cs_delta % 256 != 0) begin
      exp_w = pl;
      exp_d = 1;
      exp_sticky[2] = 1'b1;
      exp_run = 0;
    end else if (exp_count == 255) begin
      exp_w = pl;
      exp_d = 1;
      exp_sticky[4] = 1'b1;
    end else begin
      exp_w = pl;
      exp_c = 1;
      if (!pop_on_commit) exp_count++;
      if (exp_run < LOCK) exp_run++;
    end

    clear_mon();
    for (int i = 0; i < stream.size(); i++) begin
      if (i == fe_pos) begin
        send_byte(stream[i], 1'b0);
        break;
      end else if (pop_on_commit && i == stream.size() - 1) begin
        fork
          send_byte(stream[i], 1'b1);
          wait_commit_pop();
        join
      end else begin
        send_byte(stream[i], 1'b1);
      end
      if (i == glitch_after) begin
        idle(2);
        rx = 1'b0;
        repeat (OS / 2 - 1) @(negedge clk);
        rx = 1'b1;
        idle(2);
      end
    end
    idle(3);
    $display("frame %s len=%0d fe_pos=%0d commits=%0d discards=%0d count=%0d status=%02h",
             name, pl.size(), fe_pos, n_commit, n_discard, o_frames_count, o_status);
    check_outcome(name, exp_w, exp_c, exp_d);
  endtask

  initial begin
    byte_q_t pl, exp_w;
    int      len, kind, seen;

    rst_n = 1'b0;
    rx    = 1'b1;
    pop   = 1'b0;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_status", o_status, 0);
    check("rst_count", o_frames_count, 0);
    check("rst_locked", o_locked, 0);
    check("rst_strobes", {o_data_we, o_commit, o_discard}, 0);
    rst_n = 1'b1;
    idle(2);

    // Clean frame, then the same frame with a bad checksum (0x68 instead of 0x69)
    pl = {8'h11, 8'h22, 8'h33};
    run_frame(pl, 0, -1, -1, 0, "clean");
    run_frame(pl, -1, -1, -1, 0, "bad_csum");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_sticky = '0;
    @(negedge clk);
    $display("clear_status status=%02h", o_status);
    check("clear_status", o_status, exp_status());

    pulse_pop();
    pulse_pop();
    @(negedge clk);
    $display("pop twice count=%0d", o_frames_count);
    check("pop_to_zero", o_frames_count, exp_count);

    // Lock after two good frames, then framing error inside the payload
    run_frame(rand_payload($urandom_range(1, 6)), 0, -1, -1, 0, "lock1");
    run_frame(rand_payload($urandom_range(1, 6)), 0, -1, -1, 0, "lock2");
    run_frame(rand_payload(3), 0, $urandom_range(3, 4), -1, 0, "fe_payload");

    // Short low glitch between bytes must not create a byte
    run_frame(rand_payload(3), 0, -1, 1, 0, "glitch");

    // Line goes silent mid-payload
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b1;
    repeat ((TMO - 3) * OS) @(negedge clk);
    check("tmo_early", n_discard, 0);
    seen = 0;
    for (int k = 0; k < 8 * OS && seen == 0; k++) begin
      @(negedge clk);
      if (n_discard > 0) seen = 1;
    end
    exp_sticky[3] = 1'b1;
    exp_run = 0;
    idle(2);
    exp_w = {8'h01};
    $display("timeout commits=%0d discards=%0d status=%02h", n_commit, n_discard, o_status);
    check_outcome("timeout", exp_w, 0, 1);

    run_frame(pl.size() == 0 ? pl : rand_payload(0), 0, -1, -1, 0, "len_zero");

    // Randomized mix of good, bad-checksum and framing-error frames
    for (int n = 0; n < 12; n++) begin
      len  = $urandom_range(1, 6);
      kind = $urandom_range(0, 2);
      if (kind == 0) run_frame(rand_payload(len), 0, -1, -1, 0, "rnd_good");
      else if (kind == 1) run_frame(rand_payload(len), $urandom_range(1, 255), -1, -1, 0, "rnd_csum");
      else run_frame(rand_payload(len), 0, $urandom_range(0, len + 2), -1, 0, "rnd_fe");
    end

    // Drain, then fill the frame counter to its limit
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_sticky = '0;
    while (exp_count > 0) pulse_pop();
    pulse_pop();
    @(negedge clk);
    check("drain_count", o_frames_count, 0);
    for (int n = 0; n < 255; n++) run_frame(rand_payload(1), 0, -1, -1, 0, "fill");
    run_frame(rand_payload(2), 0, -1, -1, 0, "overflow");

    pulse_pop();
    @(negedge clk);
    check("pop_from_full", o_frames_count, exp_count);
    run_frame(rand_payload(2), 0, -1, -1, 1, "pop_with_commit");

    // Asynchronous reset in the middle of a payload
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    $display("async_reset count=%0d status=%02h data=%02h", o_frames_count, o_status, o_data);
    check("arst_data", o_data, 0);
    check("arst_strobes", {o_data_we, o_commit, o_discard}, 0);
    check("arst_count", o_frames_count, 0);
    check("arst_status", o_status, 0);
    check("arst_locked", o_locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
